// File: rtl/tournament_bpred.sv
// Tournament branch predictor: local-history PHT and gshare PHT, arbitrated by a
// chooser table indexed by global history. Registered prediction, 1-cycle latency.
// Tables are cleared by a post-reset sweep. Optional statistics counters are
// enabled with the BP_STATS_EN macro.
module tournament_bpred #(
  parameter int unsigned IDX_LEN   = 10,
  parameter int unsigned LHIST_LEN = 8,
  parameter int unsigned GHIST_LEN = 12,
  parameter int unsigned CTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 q_valid,
  input  logic [IDX_LEN-1:0]   q_idx,
  output logic                 p_valid,
  output logic                 p_taken,
  output logic                 p_use_global,
  input  logic                 upd_valid,
  input  logic [IDX_LEN-1:0]   upd_idx,
  input  logic                 upd_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_upd,
  output logic [31:0]          stat_hit
`endif
);

  localparam int unsigned LHT_D  = 1 << IDX_LEN;
  localparam int unsigned LPHT_D = 1 << LHIST_LEN;
  localparam int unsigned GPHT_D = 1 << GHIST_LEN;
  localparam int unsigned SW0    = (IDX_LEN > LHIST_LEN) ? IDX_LEN : LHIST_LEN;
  localparam int unsigned SW     = (SW0 > GHIST_LEN) ? SW0 : GHIST_LEN;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_WGLB = {1'b1, {(CTR_W-1){1'b0}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state;
  logic [SW-1:0]          sweep_cnt;
  logic [GHIST_LEN-1:0]   ghist;

  logic [LHIST_LEN-1:0]   lht     [0:LHT_D-1];
  logic [CTR_W-1:0]       lpht    [0:LPHT_D-1];
  logic [CTR_W-1:0]       gpht    [0:GPHT_D-1];
  logic [CTR_W-1:0]       chooser [0:GPHT_D-1];

  // Saturating up/down step for a 2^CTR_W-state counter
  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    else    return (c == '0)      ? c : c - CTR_W'(1);
  endfunction

  logic q_acc, upd_acc;
  assign q_acc   = ready & q_valid;
  assign upd_acc = ready & upd_valid;

  // Query-side lookups
  logic [LHIST_LEN-1:0] q_lh;
  logic [GHIST_LEN-1:0] q_gidx;
  logic                 q_local, q_global, q_sel;
  assign q_lh     = lht[q_idx];
  assign q_local  = lpht[q_lh][CTR_W-1];
  assign q_gidx   = ghist ^ GHIST_LEN'(q_idx);
  assign q_global = gpht[q_gidx][CTR_W-1];
  assign q_sel    = chooser[ghist][CTR_W-1];

  // Update-side lookups, all from pre-update state
  logic [LHIST_LEN-1:0] u_lh;
  logic [GHIST_LEN-1:0] u_gidx;
  logic [CTR_W-1:0]     u_lctr, u_gctr, u_cctr, u_cnext;
  logic                 u_local, u_global;
  assign u_lh     = lht[upd_idx];
  assign u_lctr   = lpht[u_lh];
  assign u_gidx   = ghist ^ GHIST_LEN'(upd_idx);
  assign u_gctr   = gpht[u_gidx];
  assign u_cctr   = chooser[ghist];
  assign u_local  = u_lctr[CTR_W-1];
  assign u_global = u_gctr[CTR_W-1];
  // Chooser only moves when the components disagree, toward the correct one
  assign u_cnext  = (u_local != u_global) ? ctr_step(u_cctr, u_global == upd_taken) : u_cctr;

  // Sweep write enables: a table is written only while the counter is within its depth
  logic sw_lht, sw_lpht, sw_gpht;
  assign sw_lht  = (sweep_cnt >> IDX_LEN)   == '0;
  assign sw_lpht = (sweep_cnt >> LHIST_LEN) == '0;
  assign sw_gpht = (sweep_cnt >> GHIST_LEN) == '0;

  // Control FSM, global history and registered prediction outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      sweep_cnt    <= '0;
      ready        <= 1'b0;
      ghist        <= '0;
      p_valid      <= 1'b0;
      p_taken      <= 1'b0;
      p_use_global <= 1'b0;
    end else begin
      p_valid <= q_acc;
      if (q_acc) begin
        p_use_global <= q_sel;
        p_taken      <= q_sel ? q_global : q_local;
      end
      if (state == INIT) begin
        ready     <= 1'b0;
        ghist     <= '0;
        sweep_cnt <= sweep_cnt + SW'(1);
        if (sweep_cnt == '1) state <= RUN;
      end else begin
        ready <= 1'b1;
        if (upd_acc) ghist <= {ghist[GHIST_LEN-2:0], upd_taken};
      end
    end
  end

  // Table storage: sweep initialisation or training writes
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      if (sw_lht)  lht[IDX_LEN'(sweep_cnt)]      <= '0;
      if (sw_lpht) lpht[LHIST_LEN'(sweep_cnt)]   <= CTR_WNT;
      if (sw_gpht) begin
        gpht[GHIST_LEN'(sweep_cnt)]    <= CTR_WNT;
        chooser[GHIST_LEN'(sweep_cnt)] <= CTR_WGLB;
      end
    end else if (upd_acc) begin
      lpht[u_lh]     <= ctr_step(u_lctr, upd_taken);
      gpht[u_gidx]   <= ctr_step(u_gctr, upd_taken);
      chooser[ghist] <= u_cnext;
      lht[upd_idx]   <= {u_lh[LHIST_LEN-2:0], upd_taken};
    end
  end

`ifdef BP_STATS_EN
  logic u_final;
  assign u_final = u_cctr[CTR_W-1] ? u_global : u_local;

  // Update and hit counters, cleared through the init sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_upd <= '0;
      stat_hit <= '0;
    end else if (state == INIT) begin
      stat_upd <= '0;
      stat_hit <= '0;
    end else if (upd_acc) begin
      stat_upd <= stat_upd + 32'd1;
      if (u_final == upd_taken) stat_hit <= stat_hit + 32'd1;
    end
  end
`endif

endmodule
